uart8: RTL and testbench
========================

UART8 -- requirements
Module: uart8

Interface
REQ-001 The module SHALL have parameter CLOCK_RATE, default 12000000: system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600: line bit rate in bits per second.
REQ-003 The module SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 The module SHALL have port rxEn  input  1: receiver enable.
REQ-006 The module SHALL have port rxIn  input  1: serial receive line, asynchronous, idle high.
REQ-007 The module SHALL have port rxBusy  output  1: receiver is mid-frame.
REQ-008 The module SHALL have port rxDone  output  1: one-cycle pulse when a valid byte has been received.
REQ-009 The module SHALL have port rxErr  output  1: one-cycle pulse on a framing error.
REQ-010 The module SHALL have port rxOut  output  8: last valid received byte.
REQ-011 The module SHALL have port txEn  input  1: transmitter enable.
REQ-012 The module SHALL have port txStart  input  1: request to send txIn.
REQ-013 The module SHALL have port txIn  input  8: byte to send.
REQ-014 The module SHALL have port txBusy  output  1: frame in progress.
REQ-015 The module SHALL have port txDone  output  1: one-cycle pulse at the end of the stop bit.
REQ-016 The module SHALL have port txOut  output  1: serial transmit line, idle high.

Function
REQ-017 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-018 The RX oversample tick SHALL occur every CLOCK_RATE/(BAUD_RATE*16) clocks (integer division; 78 at defaults); the TX bit period SHALL be CLOCK_RATE/BAUD_RATE clocks (1250).
REQ-019 rxIn SHALL pass through a 2-flop synchronizer before use.
REQ-020 The RX FSM SHALL have states IDLE, START, DATA, STOP; rxBusy=1 in START, DATA and STOP.
REQ-021 IDLE->START SHALL occur on the first tick with rxEn=1 and synchronized rxIn=0; the tick counter SHALL be cleared at that point.
REQ-022 In START, rxIn SHALL be sampled at tick 8: if 0, go to DATA; if 1 (glitch), return to IDLE with no rxErr and no rxDone.
REQ-023 In DATA, one bit SHALL be sampled every 16 ticks into a shift register, LSB first; after 8 bits go to STOP.
REQ-024 In STOP, rxIn SHALL be sampled 16 ticks later: if 1, rxOut is loaded and rxDone pulses for one clock; if 0, rxErr pulses for one clock and rxOut is unchanged. Either way, go to IDLE.
REQ-025 rxEn=0 SHALL force the RX FSM to IDLE on the next clock, aborting any frame without rxDone or rxErr.
REQ-026 The TX FSM SHALL have states IDLE, START, DATA, STOP; txBusy=1 outside IDLE.
REQ-027 txStart=1 with txEn=1 in IDLE SHALL latch txIn and drive the start bit from the next clock.
REQ-028 txStart while txBusy=1 SHALL be ignored.
REQ-029 Each TX bit SHALL last exactly one TX bit period.
REQ-030 At the end of the stop bit, txDone SHALL pulse for one clock and the TX FSM SHALL return to IDLE.
REQ-031 txEn=0 SHALL force TX to IDLE with txOut=1.

Reset
REQ-032 On rst=1 at a clock edge, both FSMs SHALL go to IDLE and all counters and shift registers SHALL clear.
REQ-033 Reset values SHALL be rxOut=0, rxBusy=0, rxDone=0, rxErr=0, txOut=1, txBusy=0, txDone=0.
REQ-034 Reset mid-frame SHALL abort the frame with no done or error pulse.

Configuration
REQ-035 Macro UART8_TX_EN defined SHALL compile in the transmitter; when undefined, TX logic SHALL be omitted, txIn/txStart/txEn SHALL be ignored, and outputs tied to txOut=1, txBusy=0, txDone=0.

Verification (12 MHz clock, 9600 baud, 1250 clocks/bit)
REQ-036 The bench SHALL drive an RX frame of 0xD6 with bits 0,0,1,1,0,1,0,1,1,1 on rxIn -> one rxDone pulse, rxOut=0xD6, rxErr=0.
REQ-037 The bench SHALL drive rxIn low for 400 clocks then high -> rxBusy drops within 8 ticks of the falling edge, with no rxDone and no rxErr.
REQ-038 The bench SHALL drive 0xD6 with the stop bit held 0 -> one rxErr pulse, rxOut keeps its previous value.
REQ-039 With UART8_TX_EN defined, the bench SHALL pulse txStart with txIn=0xD6 -> txOut sequence 0,0,1,1,0,1,0,1,1,1 at 1250 clocks per bit, txBusy for 12500 clocks, then one txDone pulse; in loopback (txOut to rxIn), rxOut=0xD6.
REQ-040 The bench SHALL assert rst mid-RX and mid-TX -> next clock shows all reset values; a subsequent frame is received correctly.
REQ-041 The bench SHALL send a valid frame with rxEn=0 -> no rxBusy, rxDone or rxErr.

Source files
------------

// File: rtl/uart8_if.sv
// Bundles the UART8 receive and transmit signals between a host and the uart8 core.
interface uart8_if;
    logic       rxEn;
    logic       rxIn;
    logic       rxBusy;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] rxOut;
    logic       txEn;
    logic       txStart;
    logic [7:0] txIn;
    logic       txBusy;
    logic       txDone;
    logic       txOut;

    modport slave (
        input  rxEn, rxIn, txEn, txStart, txIn,
        output rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
    );

    modport master (
        output rxEn, rxIn, txEn, txStart, txIn,
        input  rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
    );
endinterface

// File: rtl/uart8.sv
// 8N1 UART with a 16x oversampled receiver and a fixed-period transmitter.
// The transmitter is only built when UART8_TX_EN is defined; otherwise txOut idles high.
module uart8 #(
    parameter int unsigned CLOCK_RATE = 12000000,
    parameter int unsigned BAUD_RATE  = 9600
) (
    input  logic   clk,
    input  logic   rst,
    uart8_if.slave uart_io
);
    localparam int unsigned TickDiv = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int unsigned BitDiv  = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned TickW   = $clog2(TickDiv + 1);
    localparam int unsigned BitW    = $clog2(BitDiv + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [1:0]       rx_sync_q;
    logic             rx_s;
    logic [TickW-1:0] div_q, div_d;
    logic             tick;
    state_e           rx_state_q, rx_state_d;
    logic [3:0]       rx_tick_q, rx_tick_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_out_q, rx_out_d;
    logic             rx_done_q, rx_done_d;
    logic             rx_err_q, rx_err_d;

    assign rx_s  = rx_sync_q[1];
    assign tick  = (div_q == TickW'(TickDiv - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_q  <= 2'b11;
            div_q      <= '0;
            rx_state_q <= StIdle;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_out_q   <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], uart_io.rxIn};
            div_q      <= div_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_out_q   <= rx_out_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // rx_tick_q counts oversample ticks within the current bit; samples land mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_out_d   = rx_out_q;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;
        if (!uart_io.rxEn) begin
            rx_state_d = StIdle;
        end else if (tick) begin
            unique case (rx_state_q)
                StIdle: begin
                    if (!rx_s) begin
                        rx_state_d = StStart;
                        rx_tick_d  = '0;
                    end
                end
                StStart: begin
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d  = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_s ? StIdle : StData;
                    end else begin
                        rx_tick_d = rx_tick_q + 4'd1;
                    end
                end
                StData: begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = StStop;
                        end
                    end
                end
                StStop: begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_state_d = StIdle;
                        if (rx_s) begin
                            rx_out_d  = rx_shift_q;
                            rx_done_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign uart_io.rxBusy = (rx_state_q != StIdle);
    assign uart_io.rxDone = rx_done_q;
    assign uart_io.rxErr  = rx_err_q;
    assign uart_io.rxOut  = rx_out_q;

`ifdef UART8_TX_EN
    state_e          tx_state_q, tx_state_d;
    logic [BitW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic            tx_out_q, tx_out_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt_q == BitW'(BitDiv - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_out_q   <= tx_out_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;
        if (!uart_io.txEn) begin
            tx_state_d = StIdle;
            tx_cnt_d   = '0;
            tx_out_d   = 1'b1;
        end else begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
            unique case (tx_state_q)
                StIdle: begin
                    tx_cnt_d = '0;
                    tx_out_d = 1'b1;
                    if (uart_io.txStart) begin
                        tx_state_d = StStart;
                        tx_shift_d = uart_io.txIn;
                        tx_out_d   = 1'b0;
                    end
                end
                StStart: begin
                    if (tx_bit_end) begin
                        tx_state_d = StData;
                        tx_bit_d   = '0;
                        tx_out_d   = tx_shift_q[0];
                    end
                end
                StData: begin
                    if (tx_bit_end) begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_out_d   = tx_shift_q[1];
                        if (tx_bit_q == 3'd7) begin
                            tx_state_d = StStop;
                            tx_out_d   = 1'b1;
                        end
                    end
                end
                StStop: begin
                    if (tx_bit_end) begin
                        tx_state_d = StIdle;
                        tx_done_d  = 1'b1;
                    end
                end
            endcase
        end
    end

    assign uart_io.txBusy = (tx_state_q != StIdle);
    assign uart_io.txDone = tx_done_q;
    assign uart_io.txOut  = tx_out_q;
`else
    logic unused_tx;
    assign unused_tx      = ^{uart_io.txEn, uart_io.txStart, uart_io.txIn};
    assign uart_io.txBusy = 1'b0;
    assign uart_io.txDone = 1'b0;
    assign uart_io.txOut  = 1'b1;
`endif
endmodule

// File: tb/tb_uart8.sv
// Directed/randomised bench for uart8 at 12 MHz / 9600 baud; loopback TX checks need UART8_TX_EN.
module tb_uart8;
    localparam int unsigned BitClk = 1250;

    logic clk = 1'b0;
    logic rst;
    logic line_rx;
    logic loop_en;

    always #5 clk = ~clk;

    uart8_if u_if ();
    assign u_if.rxIn = loop_en ? u_if.txOut : line_rx;

    uart8 #(
        .CLOCK_RATE(12000000),
        .BAUD_RATE (9600)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .uart_io(u_if)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned done_cnt = 0, err_cnt = 0, busy_cnt = 0, tx_done_cnt = 0, tx_busy_cnt = 0;

    always @(negedge clk) begin
        if (u_if.rxDone) done_cnt <= done_cnt + 1;
        if (u_if.rxErr) err_cnt <= err_cnt + 1;
        if (u_if.rxBusy) busy_cnt <= busy_cnt + 1;
        if (u_if.txDone) tx_done_cnt <= tx_done_cnt + 1;
        if (u_if.txBusy) tx_busy_cnt <= tx_busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 8N1 frame as transmitted in time order: bit 0 is the start bit.
    function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
        return {stop, d, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = frame(d, stop);
        for (int i = 0; i < 10; i++) begin
            line_rx = f[i];
            repeat (BitClk) @(negedge clk);
        end
        line_rx = 1'b1;
        repeat (300) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rxOut"}, 32'(u_if.rxOut), 32'h0);
        check({tag, "_rxBusy"}, 32'(u_if.rxBusy), 32'h0);
        check({tag, "_rxDone"}, 32'(u_if.rxDone), 32'h0);
        check({tag, "_rxErr"}, 32'(u_if.rxErr), 32'h0);
        check({tag, "_txOut"}, 32'(u_if.txOut), 32'h1);
        check({tag, "_txBusy"}, 32'(u_if.txBusy), 32'h0);
        check({tag, "_txDone"}, 32'(u_if.txDone), 32'h0);
    endtask

    initial begin
        logic [7:0]  exp_out;
        logic [7:0]  r;
        logic        seen;
        int unsigned drop;
        int unsigned d0, e0, b0, td0, tb0;

        rst          = 1'b1;
        line_rx      = 1'b1;
        loop_en      = 1'b0;
        u_if.rxEn    = 1'b1;
        u_if.txEn    = 1'b1;
        u_if.txStart = 1'b0;
        u_if.txIn    = 8'h00;
        exp_out      = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst = 1'b0;
        repeat (100) @(negedge clk);

        // Valid 0xD6 frame
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hD6, 1'b1);
        exp_out = 8'hD6;
        check("d6_done", d0 + 1, done_cnt);
        check("d6_err", e0, err_cnt);
        check("d6_out", 32'(u_if.rxOut), 32'(exp_out));

        // 400-clock low glitch must be rejected at the start-bit midpoint
        d0 = done_cnt; e0 = err_cnt;
        seen = 1'b0; drop = 0;
        line_rx = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (i == 400) line_rx = 1'b1;
            if (u_if.rxBusy) seen = 1'b1;
            else if (seen && drop == 0) drop = i;
        end
        check("glitch_busy_seen", 32'(seen), 32'h1);
        // 8 ticks after entering START, plus up to one tick and the synchronizer to get there
        check("glitch_drop_time", 32'(drop != 0 && drop <= 9 * 78 + 4), 32'h1);
        check("glitch_done", d0, done_cnt);
        check("glitch_err", e0, err_cnt);

        // Random valid byte, then 0xD6 with a bad stop bit
        r = 8'($urandom);
        if (r == 8'hD6) r = 8'h5A;
        d0 = done_cnt;
        send_frame(r, 1'b1);
        exp_out = r;
        check("rand_done", d0 + 1, done_cnt);
        check("rand_out", 32'(u_if.rxOut), 32'(exp_out));
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hD6, 1'b0);
        check("ferr_err", e0 + 1, err_cnt);
        check("ferr_done", d0, done_cnt);
        check("ferr_out_kept", 32'(u_if.rxOut), 32'(exp_out));

        // Receiver disabled: a valid frame leaves no trace
        u_if.rxEn = 1'b0;
        d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
        send_frame(8'($urandom), 1'b1);
        check("dis_busy", b0, busy_cnt);
        check("dis_done", d0, done_cnt);
        check("dis_err", e0, err_cnt);
        check("dis_out", 32'(u_if.rxOut), 32'(exp_out));
        u_if.rxEn = 1'b1;
        repeat (200) @(negedge clk);

        // Reset in the middle of an RX frame (and a TX frame when built)
        d0 = done_cnt; e0 = err_cnt; td0 = tx_done_cnt;
        u_if.txIn    = 8'($urandom);
        u_if.txStart = 1'b1;
        @(negedge clk);
        u_if.txStart = 1'b0;
        line_rx = 1'b0;
        repeat (BitClk) @(negedge clk);
        line_rx = 1'b1;
        repeat (BitClk) @(negedge clk);
        line_rx = 1'b0;
        repeat (BitClk) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst     = 1'b0;
        line_rx = 1'b1;
        exp_out = 8'h00;
        repeat (2500) @(negedge clk);
        check("midrst_done", d0, done_cnt);
        check("midrst_err", e0, err_cnt);
        check("midrst_txdone", td0, tx_done_cnt);
        r = 8'($urandom);
        d0 = done_cnt;
        send_frame(r, 1'b1);
        exp_out = r;
        check("post_rst_done", d0 + 1, done_cnt);
        check("post_rst_out", 32'(u_if.rxOut), 32'(exp_out));

`ifdef UART8_TX_EN
        begin
            logic [9:0] tx_exp;
            tx_exp  = frame(8'hD6, 1'b1);
            loop_en = 1'b1;
            d0 = done_cnt; td0 = tx_done_cnt; tb0 = tx_busy_cnt;
            u_if.txIn    = 8'hD6;
            u_if.txStart = 1'b1;
            @(negedge clk);
            u_if.txStart = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(negedge clk);
                check($sformatf("tx_bit%0d_early", j), 32'(u_if.txOut), 32'(tx_exp[j]));
                if (j == 3) begin
                    // A request while busy must not disturb the frame
                    u_if.txIn    = 8'h00;
                    u_if.txStart = 1'b1;
                    @(negedge clk);
                    u_if.txStart = 1'b0;
                    repeat (1246) @(negedge clk);
                end else begin
                    repeat (1247) @(negedge clk);
                end
                check($sformatf("tx_bit%0d_late", j), 32'(u_if.txOut), 32'(tx_exp[j]));
                repeat (2) @(negedge clk);
            end
            repeat (5) @(negedge clk);
            check("tx_busy_len", tb0 + 12500, tx_busy_cnt);
            check("tx_done", td0 + 1, tx_done_cnt);
            check("tx_idle_high", 32'(u_if.txOut), 32'h1);
            check("loop_done", d0 + 1, done_cnt);
            check("loop_out", 32'(u_if.rxOut), 32'h0000_00D6);
            loop_en = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
